// File: rtl/tank_pkg.sv
// Shared tank/bullet types and screen geometry.
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_t;

  localparam logic [9:0] X_MAX  = 10'd639;
  localparam logic [9:0] Y_MAX  = 10'd479;
  localparam logic [9:0] TANK_W = 10'd32;
  localparam logic [9:0] TANK_H = 10'd32;

  localparam logic [5:0] LIFE_INIT = 6'd40;

  function automatic logic dir_valid(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position/direction registers, per-frame move/retire, pixel hit.
// Optional macro BULLET_WRAP_EN: wrap at screen edges and retire on a life counter.
module bullet_slot import tank_pkg::*; #(
  parameter logic [9:0] BULLET_W = 10'd8,
  parameter logic [9:0] BULLET_H = 10'd8,
  parameter logic [9:0] STEP     = 10'd4,
  parameter logic [9:0] X_MAX    = tank_pkg::X_MAX,
  parameter logic [9:0] Y_MAX    = tank_pkg::Y_MAX
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [2:0] spawn_dir,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       active,
  output logic       hit
);

  localparam logic [9:0] WRAP_X = X_MAX + 10'd1 - BULLET_W;
  localparam logic [9:0] WRAP_Y = Y_MAX + 10'd1 - BULLET_H;

  slot_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  dir_q, dir_d;
  logic        exit_edge, retire;
  logic        x_lo, x_hi, y_lo, y_hi;

`ifdef BULLET_WRAP_EN
  logic [5:0]  life_q, life_d;
`endif

  assign x_lo = x_q < STEP;
  assign y_lo = y_q < STEP;
  assign x_hi = ({1'b0, x_q} + {1'b0, STEP} + {1'b0, BULLET_W} - 11'd1) > {1'b0, X_MAX};
  assign y_hi = ({1'b0, y_q} + {1'b0, STEP} + {1'b0, BULLET_H} - 11'd1) > {1'b0, Y_MAX};

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    exit_edge = 1'b0;
    retire    = 1'b0;
`ifdef BULLET_WRAP_EN
    life_d    = life_q;
`endif
    if (tick && state_q == SLOT_FLYING) begin
      // The wrapped coordinate is only observable when wrapping is built in.
      case (dir_q)
        DIR_UP:    begin exit_edge = y_lo; y_d = y_lo ? WRAP_Y : y_q - STEP; end
        DIR_DOWN:  begin exit_edge = y_hi; y_d = y_hi ? 10'd0  : y_q + STEP; end
        DIR_LEFT:  begin exit_edge = x_lo; x_d = x_lo ? WRAP_X : x_q - STEP; end
        DIR_RIGHT: begin exit_edge = x_hi; x_d = x_hi ? 10'd0  : x_q + STEP; end
        default:   exit_edge = 1'b1;
      endcase
`ifdef BULLET_WRAP_EN
      life_d = life_q - 6'd1;
      retire = (life_q == 6'd1);
`else
      retire = exit_edge;
`endif
      if (retire) state_d = SLOT_IDLE;
    end else if (tick && spawn) begin
      state_d = SLOT_FLYING;
      x_d     = spawn_x;
      y_d     = spawn_y;
      dir_d   = spawn_dir;
`ifdef BULLET_WRAP_EN
      life_d  = LIFE_INIT;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
`ifdef BULLET_WRAP_EN
      life_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
`ifdef BULLET_WRAP_EN
      life_q  <= life_d;
`endif
    end
  end

  assign active = (state_q == SLOT_FLYING);
  assign hit = active &&
               ({1'b0, DrawX} >= {1'b0, x_q}) &&
               ({1'b0, DrawX} <= {1'b0, x_q} + {1'b0, BULLET_W} - 11'd1) &&
               ({1'b0, DrawY} >= {1'b0, y_q}) &&
               ({1'b0, DrawY} <= {1'b0, y_q} + {1'b0, BULLET_H} - 11'd1);

endmodule

// File: rtl/bullet_engine.sv
// Bullet pool: frame tick detect, fire latch, cooldown, muzzle placement, slot allocation.
// Optional macro BULLET_WRAP_EN is handled inside bullet_slot.
module bullet_engine import tank_pkg::*; #(
  parameter int         NUM_BULLETS = 4,
  parameter logic [9:0] BULLET_W    = 10'd8,
  parameter logic [9:0] BULLET_H    = 10'd8,
  parameter logic [9:0] TANK_W      = tank_pkg::TANK_W,
  parameter logic [9:0] TANK_H      = tank_pkg::TANK_H,
  parameter logic [9:0] STEP        = 10'd4,
  parameter logic [3:0] COOLDOWN    = 4'd8,
  parameter logic [9:0] X_MAX       = tank_pkg::X_MAX,
  parameter logic [9:0] Y_MAX       = tank_pkg::Y_MAX
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [9:0]             tank_X,
  input  logic [9:0]             tank_Y,
  input  logic [2:0]             tank_dir,
  input  logic                   is_shooting,
  output logic                   is_bullet,
  output logic [NUM_BULLETS-1:0] bullet_active,
  output logic                   shot_fired
);

  localparam logic [9:0] OFF_X = (TANK_W - BULLET_W) >> 1;
  localparam logic [9:0] OFF_Y = (TANK_H - BULLET_H) >> 1;

  logic frame_dly_q, frame_dly_d, tick_q, tick_d;
  logic fire_pending_q, fire_pending_d, shot_fired_q, shot_fired_d;
  logic [3:0] cooldown_q, cooldown_d, cd_dec;
  logic [9:0] muz_x, muz_y;
  logic       muz_legal, spawn_ok, found;
  logic [NUM_BULLETS-1:0] slot_active, slot_hit, spawn_vec;

  always_comb begin
    muz_x     = tank_X + OFF_X;
    muz_y     = tank_Y + OFF_Y;
    muz_legal = 1'b0;
    case (tank_dir)
      DIR_UP: begin
        muz_y     = tank_Y - BULLET_H;
        muz_legal = tank_Y >= BULLET_H;
      end
      DIR_DOWN: begin
        muz_y     = tank_Y + TANK_H;
        muz_legal = ({1'b0, tank_Y} + {1'b0, TANK_H} + {1'b0, BULLET_H} - 11'd1) <= {1'b0, Y_MAX};
      end
      DIR_LEFT: begin
        muz_x     = tank_X - BULLET_W;
        muz_legal = tank_X >= BULLET_W;
      end
      DIR_RIGHT: begin
        muz_x     = tank_X + TANK_W;
        muz_legal = ({1'b0, tank_X} + {1'b0, TANK_W} + {1'b0, BULLET_W} - 11'd1) <= {1'b0, X_MAX};
      end
      default: muz_legal = 1'b0;
    endcase
  end

  always_comb begin
    frame_dly_d    = frame_clk;
    tick_d         = frame_clk & ~frame_dly_q;
    fire_pending_d = tick_q ? 1'b0 : (fire_pending_q | is_shooting);
    cd_dec         = (cooldown_q != 4'd0) ? cooldown_q - 4'd1 : cooldown_q;
    // Free slots are judged on pre-tick state, so a slot retiring now stays unused this tick.
    spawn_ok       = tick_q && (fire_pending_q || is_shooting) && (cd_dec == 4'd0) &&
                     !(&slot_active) && dir_valid(tank_dir) && muz_legal;
    cooldown_d     = tick_q ? (spawn_ok ? COOLDOWN : cd_dec) : cooldown_q;
    shot_fired_d   = spawn_ok;
    spawn_vec      = '0;
    found          = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!slot_active[i] && !found) begin
        spawn_vec[i] = spawn_ok;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_dly_q    <= 1'b0;
      tick_q         <= 1'b0;
      fire_pending_q <= 1'b0;
      cooldown_q     <= '0;
      shot_fired_q   <= 1'b0;
    end else begin
      frame_dly_q    <= frame_dly_d;
      tick_q         <= tick_d;
      fire_pending_q <= fire_pending_d;
      cooldown_q     <= cooldown_d;
      shot_fired_q   <= shot_fired_d;
    end
  end

  bullet_slot #(
    .BULLET_W(BULLET_W), .BULLET_H(BULLET_H), .STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_slot [NUM_BULLETS-1:0] (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (tick_q),
    .spawn     (spawn_vec),
    .spawn_x   (muz_x),
    .spawn_y   (muz_y),
    .spawn_dir (tank_dir),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .active    (slot_active),
    .hit       (slot_hit)
  );

  assign is_bullet     = |slot_hit;
  assign bullet_active = slot_active;
  assign shot_fired    = shot_fired_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: default build plus a zero-cooldown instance.
module tb_bullet_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, tank_X = '0, tank_Y = '0;
  logic [2:0] tank_dir = '0;
  logic       is_shooting = 1'b0;

  logic       is_bullet, shot_fired, is_bullet_c0, shot_fired_c0;
  logic [3:0] bullet_active, bullet_active_c0;

  int checks = 0;
  int errors = 0;
  logic sf, sf0, sfa, h, h0;

  always #5 Clk = ~Clk;

  bullet_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .tank_X(tank_X), .tank_Y(tank_Y), .tank_dir(tank_dir), .is_shooting(is_shooting),
    .is_bullet(is_bullet), .bullet_active(bullet_active), .shot_fired(shot_fired)
  );

  bullet_engine #(.COOLDOWN(4'd0)) dut_c0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .tank_X(tank_X), .tank_Y(tank_Y), .tank_dir(tank_dir), .is_shooting(is_shooting),
    .is_bullet(is_bullet_c0), .bullet_active(bullet_active_c0), .shot_fired(shot_fired_c0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; is_shooting = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // One frame: tick lands on the second posedge; shot_fired sampled after it and one cycle later.
  task automatic frame(input logic fire, output logic o_sf, output logic o_sf0, output logic o_after);
    @(negedge Clk);
    frame_clk = 1'b1; is_shooting = fire;
    @(negedge Clk);
    @(negedge Clk);
    is_shooting = 1'b0; o_sf = shot_fired; o_sf0 = shot_fired_c0;
    @(negedge Clk);
    o_after = shot_fired | shot_fired_c0; frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic o_h, output logic o_h0);
    @(negedge Clk);
    DrawX = x; DrawY = y;
    #1;
    o_h = is_bullet; o_h0 = is_bullet_c0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_active", bullet_active, 4'b0000);
    chk("rst_shot", shot_fired, 1'b0);
    probe(10'd0, 10'd0, h, h0);
    chk("rst_is_bullet", h, 1'b0);

    // Basic spawn up, then three moves with tank_dir changed (latched dir must win)
    tank_X = 10'd300; tank_Y = 10'd240; tank_dir = 3'd1;
    frame(1'b1, sf, sf0, sfa);
    chk("t1_shot", sf, 1'b1);
    chk("t1_shot_pulse", sfa, 1'b0);
    chk("t1_active", bullet_active, 4'b0001);
    probe(10'd312, 10'd232, h, h0); chk("t1_hit_tl", h, 1'b1);
    probe(10'd311, 10'd232, h, h0); chk("t1_miss_left", h, 1'b0);
    probe(10'd319, 10'd239, h, h0); chk("t1_hit_br", h, 1'b1);
    probe(10'd320, 10'd239, h, h0); chk("t1_miss_right", h, 1'b0);
    probe(10'd312, 10'd231, h, h0); chk("t1_miss_above", h, 1'b0);
    tank_dir = 3'd4;
    for (int k = 0; k < 3; k++) frame(1'b0, sf, sf0, sfa);
    probe(10'd312, 10'd220, h, h0); chk("t1_moved_top", h, 1'b1);
    probe(10'd312, 10'd219, h, h0); chk("t1_moved_above", h, 1'b0);
    probe(10'd312, 10'd227, h, h0); chk("t1_moved_bot", h, 1'b1);
    probe(10'd312, 10'd228, h, h0); chk("t1_moved_below", h, 1'b0);
    chk("t1_active_after", bullet_active, 4'b0001);

    // Illegal up muzzle drops request, cooldown untouched
    do_reset();
    tank_X = 10'd300; tank_Y = 10'd4; tank_dir = 3'd1;
    frame(1'b1, sf, sf0, sfa);
    chk("t2_no_shot", sf, 1'b0);
    chk("t2_no_active", bullet_active, 4'b0000);
    tank_Y = 10'd240;
    frame(1'b1, sf, sf0, sfa);
    chk("t2_next_shot", sf, 1'b1);
    chk("t2_next_active", bullet_active, 4'b0001);

    // Cooldown of 8: first accepted, ticks 1..7 blocked, tick 8 accepted
    do_reset();
    tank_X = 10'd300; tank_Y = 10'd240; tank_dir = 3'd1;
    frame(1'b1, sf, sf0, sfa);
    chk("t3_first", sf, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      frame((k <= 4) || (k >= 7), sf, sf0, sfa);
      chk($sformatf("t3_tick%0d", k), sf, (k == 8));
    end
    chk("t3_active", bullet_active, 4'b0011);

    // Request between ticks is latched and honoured, then cleared
    do_reset();
    tank_X = 10'd300; tank_Y = 10'd240; tank_dir = 3'd1;
    @(negedge Clk); is_shooting = 1'b1;
    @(negedge Clk); is_shooting = 1'b0;
    @(negedge Clk);
    frame(1'b0, sf, sf0, sfa);
    chk("latch_shot", sf0, 1'b1);
    chk("latch_active", bullet_active_c0, 4'b0001);
    frame(1'b0, sf, sf0, sfa);
    chk("latch_cleared", sf0, 1'b0);

    // Zero cooldown: fill slots in order, drop when full, reuse retired slot1
    do_reset();
    tank_X = 10'd300; tank_Y = 10'd240; tank_dir = 3'd1;
    frame(1'b1, sf, sf0, sfa); chk("t4_s0", bullet_active_c0, 4'b0001);
    tank_Y = 10'd20;
    frame(1'b1, sf, sf0, sfa); chk("t4_s1", bullet_active_c0, 4'b0011);
    tank_Y = 10'd240;
    frame(1'b1, sf, sf0, sfa); chk("t4_s2", bullet_active_c0, 4'b0111);
    frame(1'b1, sf, sf0, sfa); chk("t4_s3", bullet_active_c0, 4'b1111);
    frame(1'b1, sf, sf0, sfa);
    chk("t4_full_drop", sf0, 1'b0);
    chk("t4_full_active", bullet_active_c0, 4'b1111);
    frame(1'b1, sf, sf0, sfa);
    chk("t4_retire_noreuse", sf0, 1'b0);
    chk("t4_retired", bullet_active_c0, 4'b1101);
    frame(1'b1, sf, sf0, sfa);
    chk("t4_reuse_shot", sf0, 1'b1);
    chk("t4_reuse", bullet_active_c0, 4'b1111);
    probe(10'd312, 10'd235, h, h0); chk("t4_reuse_pos", h0, 1'b1);

    // Right edge: 628 moves to 632, then retires
    do_reset();
    tank_X = 10'd596; tank_Y = 10'd200; tank_dir = 3'd2;
    frame(1'b1, sf, sf0, sfa);
    chk("t5_shot", sf, 1'b1);
    probe(10'd628, 10'd212, h, h0); chk("t5_hit628", h, 1'b1);
    probe(10'd627, 10'd212, h, h0); chk("t5_miss627", h, 1'b0);
    frame(1'b0, sf, sf0, sfa);
    probe(10'd632, 10'd212, h, h0); chk("t5_hit632", h, 1'b1);
    probe(10'd639, 10'd219, h, h0); chk("t5_hit639", h, 1'b1);
    probe(10'd631, 10'd212, h, h0); chk("t5_miss631", h, 1'b0);
    chk("t5_still_active", bullet_active, 4'b0001);
    frame(1'b0, sf, sf0, sfa);
    chk("t5_retired", bullet_active, 4'b0000);
    probe(10'd632, 10'd212, h, h0); chk("t5_gone", h, 1'b0);

    // Right muzzle legality boundary: 601 illegal, 600 legal
    do_reset();
    tank_X = 10'd601; tank_Y = 10'd200; tank_dir = 3'd2;
    frame(1'b1, sf, sf0, sfa);
    chk("edge_601", sf, 1'b0);
    tank_X = 10'd600;
    frame(1'b1, sf, sf0, sfa);
    chk("edge_600", sf, 1'b1);
    chk("edge_600_active", bullet_active, 4'b0001);

    // Invalid direction never spawns
    do_reset();
    tank_X = 10'd300; tank_Y = 10'd240; tank_dir = 3'd5;
    frame(1'b1, sf, sf0, sfa);
    chk("bad_dir", sf0, 1'b0);

    // Reset mid-flight
    do_reset();
    tank_X = 10'd300; tank_Y = 10'd240; tank_dir = 3'd1;
    for (int k = 0; k < 3; k++) frame(1'b1, sf, sf0, sfa);
    chk("t6_pre", bullet_active_c0, 4'b0111);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    chk("t6_active", bullet_active, 4'b0000);
    chk("t6_active_c0", bullet_active_c0, 4'b0000);
    chk("t6_shot", shot_fired_c0, 1'b0);
    Reset = 1'b0;
    probe(10'd312, 10'd232, h, h0); chk("t6_pix_a", h0, 1'b0);
    probe(10'd312, 10'd224, h, h0); chk("t6_pix_b", h | h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
